// File: rtl/nested_prio_reg.sv
// Nested-priority result register with an IDLE/ACTIVE/HOLD controller that counts
// changing updates and freezes the datapath once LIMIT changes have been seen.
module nested_prio_reg #(
  parameter  int WIDTH     = 2,
  parameter  int B_DEFAULT = 3,
  parameter  int LIMIT     = 4,
  localparam int CNTW      = $clog2(LIMIT + 1)
) (
  input  logic             _clock,
  input  logic             _reset,
  input  logic             a,
  input  logic [1:0]       c,
  input  logic [WIDTH-1:0] in_val,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] d,
  output logic             upd,
  output logic [CNTW-1:0]  cnt,
  output logic [1:0]       st
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] B_DEF   = WIDTH'(B_DEFAULT);
  localparam logic [CNTW-1:0]  LIMIT_C = CNTW'(LIMIT);

  state_t           st_q, st_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             upd_q, upd_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  always_ff @(posedge _clock) begin
    if (_reset) begin
      st_q  <= IDLE;
      b_q   <= '0;
      d_q   <= '0;
      upd_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      b_q   <= b_d;
      d_q   <= d_d;
      upd_q <= upd_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    st_d  = st_q;
    b_d   = b_q;
    d_d   = d_q;
    cnt_d = cnt_q;
    upd_d = 1'b0;
    case (st_q)
      IDLE, ACTIVE: begin
        // Load wins over increment; a=0 falls back to the default value.
        if (a) begin
          if (c[0]) begin
            b_d = in_val;
          end else if (c[1]) begin
            d_d = b_q;
            b_d = b_q + 1'b1;
          end
        end else begin
          b_d = B_DEF;
        end
        upd_d = (b_d != b_q);

        if (st_q == IDLE) begin
          if (a) begin
            st_d  = ACTIVE;
            cnt_d = '0;
          end
        end else if (!a) begin
          st_d = IDLE;
        end else if (upd_d && (cnt_q < LIMIT_C)) begin
          if (cnt_q + 1'b1 == LIMIT_C) begin
            st_d  = HOLD;
            cnt_d = LIMIT_C;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        // Datapath frozen; only a=0 releases, and b keeps its frozen value.
        if (!a) begin
          st_d  = IDLE;
          cnt_d = '0;
        end
      end
      default: begin
        st_d = IDLE;
      end
    endcase
  end

  assign b   = b_q;
  assign d   = d_q;
  assign upd = upd_q;
  assign cnt = cnt_q;
  assign st  = st_q;

endmodule

// File: tb/tb_nested_prio_reg.sv
// Scoreboard bench for nested_prio_reg: the stimulus process queues the expected
// register state for each edge, and a negedge monitor pops and compares it.
module tb_nested_prio_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       a;
  logic [1:0] c;
  logic [1:0] in_val;
  logic [1:0] b;
  logic [1:0] d;
  logic       upd;
  logic [2:0] cnt;
  logic [1:0] st;

  typedef struct packed {
    logic [1:0] b;
    logic [1:0] d;
    logic       upd;
    logic [2:0] cnt;
    logic [1:0] st;
  } exp_t;

  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;
  int   txn    = 0;

  nested_prio_reg #(.WIDTH(2), .B_DEFAULT(3), .LIMIT(4)) dut (
    ._clock(clk),
    ._reset(rst),
    .a      (a),
    .c      (c),
    .in_val (in_val),
    .b      (b),
    .d      (d),
    .upd    (upd),
    .cnt    (cnt),
    .st     (st)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("[TB] FAIL txn %0d %s: got %0d expected %0d", txn, name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      txn++;
      $display("[TB] txn %0d: b=%0d d=%0d upd=%0d cnt=%0d st=%0d", txn, b, d, upd, cnt, st);
      check("b",   int'(b),   int'(e.b));
      check("d",   int'(d),   int'(e.d));
      check("upd", int'(upd), int'(e.upd));
      check("cnt", int'(cnt), int'(e.cnt));
      check("st",  int'(st),  int'(e.st));
    end
  end

  // One edge: drive inputs, let the edge happen, then queue what it should produce.
  task automatic step(input logic r, input logic aa, input logic [1:0] cc,
                      input logic [1:0] iv, input logic [1:0] eb, input logic [1:0] ed,
                      input logic eu, input logic [2:0] ec, input logic [1:0] es);
    exp_t e;
    rst = r; a = aa; c = cc; in_val = iv;
    @(posedge clk);
    #1;
    e.b = eb; e.d = ed; e.upd = eu; e.cnt = ec; e.st = es;
    sb.push_back(e);
  endtask

  initial begin
    int guard;
    //    rst a  c      in     b  d  upd cnt st
    step(1, 1, 2'b01, 2'd2, 0, 0, 0, 0, 0);   // reset overrides load
    step(1, 1, 2'b01, 2'd2, 0, 0, 0, 0, 0);
    step(0, 0, 2'b00, 2'd0, 3, 0, 1, 0, 0);   // default load
    step(0, 0, 2'b00, 2'd0, 3, 0, 0, 0, 0);   // equal write, no upd
    step(0, 1, 2'b11, 2'd1, 1, 0, 1, 0, 1);   // load priority, enter ACTIVE
    step(0, 1, 2'b01, 2'd3, 3, 0, 1, 1, 1);   // changing load counts
    step(0, 1, 2'b10, 2'd0, 0, 3, 1, 2, 1);   // increment wraps 3->0
    step(0, 1, 2'b01, 2'd0, 0, 3, 0, 2, 1);   // equal load does not count
    step(0, 1, 2'b00, 2'd2, 0, 3, 0, 2, 1);   // c=0 holds
    step(0, 0, 2'b10, 2'd0, 3, 3, 1, 2, 0);   // ACTIVE->IDLE, cnt holds
    step(1, 0, 2'b00, 2'd0, 0, 0, 0, 0, 0);   // reset from b=3: no upd
    step(0, 1, 2'b10, 2'd0, 1, 0, 1, 0, 1);   // count run to HOLD
    step(0, 1, 2'b10, 2'd0, 2, 1, 1, 1, 1);
    step(0, 1, 2'b10, 2'd0, 3, 2, 1, 2, 1);
    step(0, 1, 2'b10, 2'd0, 0, 3, 1, 3, 1);
    step(0, 1, 2'b10, 2'd0, 1, 0, 1, 4, 2);
    step(0, 1, 2'b10, 2'd0, 1, 0, 0, 4, 2);   // HOLD frozen
    step(0, 1, 2'b01, 2'd3, 1, 0, 0, 4, 2);   // HOLD ignores load
    step(0, 0, 2'b00, 2'd0, 1, 0, 0, 0, 0);   // HOLD->IDLE, b holds
    step(0, 0, 2'b00, 2'd0, 3, 0, 1, 0, 0);   // default loads next edge
    step(0, 1, 2'b10, 2'd0, 0, 3, 1, 0, 1);   // second run to HOLD
    step(0, 1, 2'b10, 2'd0, 1, 0, 1, 1, 1);
    step(0, 1, 2'b10, 2'd0, 2, 1, 1, 2, 1);
    step(0, 1, 2'b10, 2'd0, 3, 2, 1, 3, 1);
    step(0, 1, 2'b10, 2'd0, 0, 3, 1, 4, 2);
    step(1, 1, 2'b10, 2'd0, 0, 0, 0, 0, 0);   // reset mid-HOLD
    step(0, 1, 2'b11, 2'd2, 2, 0, 1, 0, 1);   // resumes normally
    rst = 0; a = 0; c = 2'b00; in_val = 2'd0;
    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      tests++;
      failed++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
